// File: rtl/sfq_pulse_window_counter.sv
// sfq_pulse_window_counter
// Clocked monitor for an asynchronous, toggle-encoded SFQ pulse line.
// Every edge on `a` is one pulse. The block counts pulses over fixed windows of
// WINDOW enabled clk cycles and publishes each window's saturated count with a
// one-cycle strobe. A source that stays silent for IDLE_LIMIT consecutive
// windows (stuck or tied low) raises q_stuck.
module sfq_pulse_window_counter #(
  parameter int unsigned WINDOW     = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned IDLE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  output logic [CNT_W-1:0] q_cnt,
  output logic             q_vld,
  output logic             q_ovf,
  output logic             q_stuck
);

  localparam int unsigned WIN_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned IDLE_W    = $clog2(IDLE_LIMIT + 1);
  localparam int unsigned SUM_W     = CNT_W + 1;
  localparam int unsigned ARM_W     = 2;
  localparam int unsigned ARM_EDGES = 3;

  localparam logic [0:0] ST_ARM   = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_EDGES - 1);

  // Synchroniser and edge detector state
  logic              r_a_s1;
  logic              r_a_s2;
  logic              r_a_prev;

  // Control state
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ARM_W-1:0]  r_arm_cnt;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [CNT_W-1:0]  r_evt_cnt;
  logic              r_sat;
  logic [IDLE_W-1:0] r_idle_cnt;

  // Combinational datapath
  logic              w_evt;
  logic              w_count_en;
  logic              w_close;
  logic [SUM_W-1:0]  w_sum;
  logic              w_sum_ovf;
  logic [CNT_W-1:0]  w_sum_sat;
  logic              w_win_zero;
  logic [IDLE_W-1:0] w_idle_inc;

  // Two-flop synchroniser; a_prev follows a_s2 on every edge, even when
  // counting is frozen, so re-enabling never sees a stale level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_s1   <= 1'b0;
      r_a_s2   <= 1'b0;
      r_a_prev <= 1'b0;
    end else begin
      r_a_s1   <= a;
      r_a_s2   <= r_a_s1;
      r_a_prev <= r_a_s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: ARM lasts ARM_EDGES edges while the synchroniser settles
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARM: begin
        if (r_arm_cnt == ARM_LAST) begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        w_state_nxt = ST_COUNT;
      end
      default: begin
        w_state_nxt = ST_ARM;
      end
    endcase
  end

  // ARM edge counter; frozen once counting starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= '0;
    end else if (r_state == ST_ARM) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  // Event detect, saturating add and window-close decode
  always_comb begin
    w_evt      = 1'b0;
    w_count_en = 1'b0;
    w_close    = 1'b0;
    w_sum      = '0;
    w_sum_ovf  = 1'b0;
    w_sum_sat  = '0;
    w_win_zero = 1'b0;
    w_idle_inc = r_idle_cnt;

    w_evt      = r_a_s2 ^ r_a_prev;
    w_count_en = (r_state == ST_COUNT) && en;
    w_close    = w_count_en && (r_win_cnt == WIN_LAST);

    w_sum      = {1'b0, r_evt_cnt} + SUM_W'(w_evt);
    w_sum_ovf  = w_sum[CNT_W];
    w_sum_sat  = w_sum_ovf ? CNT_MAX : w_sum[CNT_W-1:0];
    w_win_zero = (w_sum_sat == '0);

    if (r_idle_cnt != IDLE_MAX) begin
      w_idle_inc = r_idle_cnt + IDLE_W'(1);
    end
  end

  // Window position, running event count and saturation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_evt_cnt <= '0;
      r_sat     <= 1'b0;
    end else if (w_close) begin
      r_win_cnt <= '0;
      r_evt_cnt <= '0;
      r_sat     <= 1'b0;
    end else if (w_count_en) begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
      r_evt_cnt <= w_sum_sat;
      r_sat     <= r_sat | w_sum_ovf;
    end
  end

  // Result registers; an event on the closing edge belongs to the closing window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= 1'b0;
      q_cnt <= '0;
      q_ovf <= 1'b0;
    end else begin
      q_vld <= w_close;
      if (w_close) begin
        q_cnt <= w_sum_sat;
        q_ovf <= r_sat | w_sum_ovf;
      end
    end
  end

  // Silent-window tracking; q_stuck rises with the strobe that reaches the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      q_stuck    <= 1'b0;
    end else if (w_close) begin
      if (w_win_zero) begin
        r_idle_cnt <= w_idle_inc;
        q_stuck    <= q_stuck | (w_idle_inc == IDLE_MAX);
      end else begin
        r_idle_cnt <= '0;
        q_stuck    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfq_pulse_window_counter.sv
// Directed bench for sfq_pulse_window_counter. Two instances: the default
// configuration and a 3-bit counter variant used for saturation.
// Inputs change 1 time unit after a rising edge; every strobe is recorded on
// the falling edge together with the number of edges since reset release.
module tb_sfq_pulse_window_counter;

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
    int stuck;
  } rec_t;

  typedef struct {
    int n_tog;
    int start;
    int gap;
    int exp_cnt;
    int exp_ovf;
    int exp_stuck;
  } win_vec_t;

  localparam int NVEC = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       a;
  logic       a1;
  logic [7:0] q0_cnt;
  logic       q0_vld;
  logic       q0_ovf;
  logic       q0_stuck;
  logic [2:0] q1_cnt;
  logic       q1_vld;
  logic       q1_ovf;
  logic       q1_stuck;

  int       cyc;
  int       n_tests;
  int       n_fail;
  rec_t     q0[$];
  rec_t     q1[$];
  rec_t     m0;
  rec_t     m1;
  win_vec_t vecs[NVEC];

  always #5 clk = ~clk;

  sfq_pulse_window_counter #(.WINDOW(16), .CNT_W(8), .IDLE_LIMIT(4)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a),
    .q_cnt   (q0_cnt),
    .q_vld   (q0_vld),
    .q_ovf   (q0_ovf),
    .q_stuck (q0_stuck)
  );

  sfq_pulse_window_counter #(.WINDOW(16), .CNT_W(3), .IDLE_LIMIT(4)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a1),
    .q_cnt   (q1_cnt),
    .q_vld   (q1_vld),
    .q_ovf   (q1_ovf),
    .q_stuck (q1_stuck)
  );

  // Edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Strobe recorder
  always @(negedge clk) begin
    if (!rst && q0_vld) begin
      m0.cyc = cyc; m0.cnt = int'(q0_cnt); m0.ovf = int'(q0_ovf); m0.stuck = int'(q0_stuck);
      q0.push_back(m0);
    end
    if (!rst && q1_vld) begin
      m1.cyc = cyc; m1.cnt = int'(q1_cnt); m1.ovf = int'(q1_ovf); m1.stuck = int'(q1_stuck);
      q1.push_back(m1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench just after edge 1 following release
  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic chk_rec0(input string tag, input int idx, input int e_cyc,
                          input int e_cnt, input int e_ovf, input int e_stuck);
    if (idx >= q0.size()) begin
      chk({tag, " strobe present"}, q0.size(), idx + 1);
    end else begin
      chk({tag, " cycle"}, q0[idx].cyc, e_cyc);
      chk({tag, " q_cnt"}, q0[idx].cnt, e_cnt);
      chk({tag, " q_ovf"}, q0[idx].ovf, e_ovf);
      chk({tag, " q_stuck"}, q0[idx].stuck, e_stuck);
    end
  endtask

  task automatic chk_rec1(input string tag, input int idx, input int e_cyc,
                          input int e_cnt, input int e_ovf, input int e_stuck);
    if (idx >= q1.size()) begin
      chk({tag, " strobe present"}, q1.size(), idx + 1);
    end else begin
      chk({tag, " cycle"}, q1[idx].cyc, e_cyc);
      chk({tag, " q_cnt"}, q1[idx].cnt, e_cnt);
      chk({tag, " q_ovf"}, q1[idx].ovf, e_ovf);
      chk({tag, " q_stuck"}, q1[idx].stuck, e_stuck);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    en  = 1'b1;
    a   = 1'b0;
    a1  = 1'b0;

    // One record per window: toggles driven at offsets start + k*gap.
    // A toggle driven after edge 16w+1+off is counted at edge 16w+4+off,
    // inside window w whose close edge is 16w+19.
    vecs[0]  = '{0, 0, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 0, 1};   // 4th silent window raises stuck
    vecs[4]  = '{0, 0, 1, 0, 0, 1};   // stuck holds
    vecs[5]  = '{5, 1, 3, 5, 0, 0};   // activity clears stuck
    vecs[6]  = '{0, 0, 1, 0, 0, 0};
    vecs[7]  = '{2, 0, 2, 2, 0, 0};
    vecs[8]  = '{1, 15, 1, 1, 0, 0};  // event lands on the closing edge
    vecs[9]  = '{1, 0, 1, 1, 0, 0};   // event on the first edge of a window
    vecs[10] = '{8, 0, 2, 8, 0, 0};

    // Reset values
    #2;
    chk("reset q_cnt", int'(q0_cnt), 0);
    chk("reset q_vld", int'(q0_vld), 0);
    chk("reset q_stuck", int'(q0_stuck), 0);

    // Phase A: window table on the default instance
    do_reset();
    for (int w = 0; w < NVEC; w++) begin
      for (int off = 0; off < 16; off++) begin
        if (vecs[w].n_tog > 0 && off >= vecs[w].start &&
            ((off - vecs[w].start) % vecs[w].gap) == 0 &&
            ((off - vecs[w].start) / vecs[w].gap) < vecs[w].n_tog) begin
          a = ~a;
        end
        step();
      end
    end
    step(); step(); step();
    chk("A strobe count", q0.size(), NVEC);
    for (int w = 0; w < NVEC; w++) begin
      chk_rec0($sformatf("A w%0d", w), w, 19 + 16 * w,
               vecs[w].exp_cnt, vecs[w].exp_ovf, vecs[w].exp_stuck);
    end

    // Phase B: enable dropped for 10 cycles while a toggles 3 times
    a = 1'b0;
    en = 1'b1;
    do_reset();
    for (int c = 1; c <= 62; c++) begin
      en = (c >= 21 && c <= 30) ? 1'b0 : 1'b1;
      if (c == 18 || c == 22 || c == 25 || c == 28) a = ~a;
      step();
    end
    chk("B strobe count", q0.size(), 3);
    chk_rec0("B w0", 0, 19, 0, 0, 0);
    chk_rec0("B w1 delayed", 1, 45, 1, 0, 0);
    chk_rec0("B w2", 2, 61, 0, 0, 0);

    // Phase C: a high through reset and release
    en = 1'b1;
    rst = 1'b1;
    a = 1'b1;
    do_reset();
    for (int c = 1; c <= 20; c++) step();
    chk("C strobe count", q0.size(), 1);
    chk_rec0("C first window", 0, 19, 0, 0, 0);

    // Phase D: reset pulsed mid-window with win_cnt=9, evt_cnt=3
    a = 1'b0;
    do_reset();
    for (int c = 1; c <= 27; c++) begin
      if (c == 1 || c == 3 || c == 5 || c == 7 || c == 17 || c == 19 || c == 21) a = ~a;
      step();
    end
    chk("D strobe count pre-reset", q0.size(), 1);
    chk_rec0("D w0", 0, 19, 4, 0, 0);
    chk("D q_cnt pre-reset", int'(q0_cnt), 4);
    rst = 1'b1;
    #1;
    chk("D q_cnt async clear", int'(q0_cnt), 0);
    chk("D q_vld async clear", int'(q0_vld), 0);
    chk("D q_ovf async clear", int'(q0_ovf), 0);
    chk("D q_stuck async clear", int'(q0_stuck), 0);
    q0.delete();
    q1.delete();
    #1;
    rst = 1'b0;
    step();
    for (int c = 1; c <= 20; c++) step();
    chk("D strobe count post-reset", q0.size(), 1);
    chk_rec0("D first window after release", 0, 19, 0, 0, 0);

    // Phase E: 3-bit counter saturation, then a quiet window
    a = 1'b0;
    a1 = 1'b0;
    do_reset();
    for (int c = 1; c <= 69; c++) begin
      if (c <= 48 && (c % 2) == 1) a1 = ~a1;
      step();
    end
    chk("E strobe count", q1.size(), 4);
    chk_rec1("E w0 sat", 0, 19, 7, 1, 0);
    chk_rec1("E w1 sat", 1, 35, 7, 1, 0);
    chk_rec1("E w2 sat", 2, 51, 7, 1, 0);
    chk_rec1("E w3 quiet", 3, 67, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
